// File: rtl/uart_tx_sched.sv
// Word-to-byte sequencer between the CPU TX word FIFO and the byte-wide UART core.
// Each popped word is sent as 1-4 bytes, and every byte waits for a full tx_busy rise and fall.
module uart_tx_sched #(
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_7EF0,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [31:0]          address,
  input  logic [31:0]          dataIn,
  input  logic                 fifo_empty,
  input  logic [31:0]          fifo_data,
  output logic                 fifo_rd,
  output logic                 tx_ena,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 idle,
  output logic                 ack_err,
  output logic [CNT_WIDTH-1:0] words_sent
);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_ACK, S_WAIT_DONE, S_NEXT
  } state_t;

  state_t               state_q, state_d;
  logic                 en_q, en_d;
  logic [1:0]           nbytes_q, nbytes_d;
  logic                 msb_q, msb_d;
  logic [1:0]           w_nbytes_q, w_nbytes_d;
  logic                 w_msb_q, w_msb_d;
  logic [31:0]          shift_q, shift_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 ack_err_q, ack_err_d;
  logic [CNT_WIDTH-1:0] words_q, words_d;
  logic                 ctrl_wr;
  logic [1:0]           byte_sel;
  logic                 unused_bits;

  assign ctrl_wr     = we && (address == CTRL_ADDR);
  assign unused_bits = ^dataIn[31:5];

  // byte_cnt only moves in NEXT, so tx_data is stable for the whole byte handshake
  assign byte_sel   = w_msb_q ? (w_nbytes_q - byte_cnt_q) : byte_cnt_q;
  assign tx_data    = shift_q[{byte_sel, 3'b000} +: 8];
  assign idle       = (state_q == S_IDLE);
  assign ack_err    = ack_err_q;
  assign words_sent = words_q;

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    nbytes_d   = nbytes_q;
    msb_d      = msb_q;
    w_nbytes_d = w_nbytes_q;
    w_msb_d    = w_msb_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    timer_d    = timer_q;
    ack_err_d  = ack_err_q;
    words_d    = words_q;
    fifo_rd    = 1'b0;
    tx_ena     = 1'b0;

    if (ctrl_wr) begin
      en_d     = dataIn[0];
      nbytes_d = dataIn[2:1];
      msb_d    = dataIn[3];
      if (dataIn[4]) ack_err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: if (en_q && !fifo_empty) state_d = S_LOAD;
      S_LOAD: begin
        fifo_rd    = !fifo_empty;
        shift_d    = fifo_data;
        byte_cnt_d = 2'd0;
        w_nbytes_d = nbytes_q;
        w_msb_d    = msb_q;
        state_d    = S_SEND;
      end
      S_SEND: if (!tx_busy) begin
        tx_ena  = 1'b1;
        timer_d = TW'(1);  // the tx_ena cycle counts toward the timeout
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q >= TW'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;  // overrides a same-cycle clear
          state_d   = S_NEXT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_DONE: if (!tx_busy) state_d = S_NEXT;
      S_NEXT: begin
        if (byte_cnt_q == w_nbytes_q) begin
          words_d = words_q + CNT_WIDTH'(1);
          state_d = (fifo_empty || !en_q) ? S_IDLE : S_LOAD;
        end else begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          state_d    = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b1;
      nbytes_q   <= 2'd3;
      msb_q      <= 1'b0;
      w_nbytes_q <= 2'd0;
      w_msb_q    <= 1'b0;
      shift_q    <= 32'h0;
      byte_cnt_q <= 2'd0;
      timer_q    <= '0;
      ack_err_q  <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      nbytes_q   <= nbytes_d;
      msb_q      <= msb_d;
      w_nbytes_q <= w_nbytes_d;
      w_msb_q    <= w_msb_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      timer_q    <= timer_d;
      ack_err_q  <= ack_err_d;
      words_q    <= words_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a queue-based FIFO and UART busy model drive the DUT,
// expected bytes are queued when words are pushed and a monitor checks each tx_ena.
module tb_uart_tx_sched;
  localparam int          ACK_TIMEOUT = 16;
  localparam logic [31:0] CTRL_ADDR   = 32'h0000_7EF0;

  logic        clk = 1'b0, reset_n = 1'b0, we = 1'b0;
  logic [31:0] address = '0, dataIn = '0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = '0;
  logic        fifo_rd, tx_ena, idle, ack_err;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [15:0] words_sent;

  always #5 clk = ~clk;

  uart_tx_sched #(.CTRL_ADDR(CTRL_ADDR), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .address(address), .dataIn(dataIn),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .tx_ena(tx_ena), .tx_data(tx_data), .tx_busy(tx_busy), .idle(idle),
    .ack_err(ack_err), .words_sent(words_sent)
  );

  typedef struct {logic [7:0] b; bit last;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];

  int  total = 0, bad = 0;
  bit  en_m = 1'b1, msb_m = 1'b0;
  int  nb_m = 3;
  int  exp_words = 0, ena_cnt = 0, rd_cnt = 0;
  logic [15:0] prev_ws = '0;
  bit  pop_pending = 0, dead_mode = 0, gate_wait = 0, in_byte = 0;
  logic [7:0] held_byte = '0;
  int  rise_cd = 0, fall_cd = 0, busy_len = 3, bmin = 2, bmax = 5;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  function automatic void fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
  endfunction

  // FIFO pop lands just after the edge on which the DUT sampled fifo_rd
  always begin
    @(posedge clk);
    #1;
    if (pop_pending) begin
      pop_pending = 0;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_refresh();
    end
  end

  // UART busy model followed by the output monitor
  always begin
    exp_t e;
    @(negedge clk);
    if (rise_cd > 0) begin
      rise_cd--;
      if (rise_cd == 0) begin tx_busy = 1'b1; fall_cd = busy_len; end
    end else if (fall_cd > 0) begin
      fall_cd--;
      if (fall_cd == 0) begin tx_busy = 1'b0; gate_wait = 0; end
    end
    #1;
    if (reset_n) begin
      if (fifo_rd) begin
        rd_cnt++;
        pop_pending = 1;
        check("rd_while_empty", {31'b0, fifo_empty}, 32'd0);
      end
      if (tx_ena) begin
        ena_cnt++;
        check("ena_while_busy_cycle", {31'b0, gate_wait}, 32'd0);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_byte_unexpected got=%0h exp=none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {24'b0, tx_data}, {24'b0, e.b});
          if (e.last) exp_words++;
          held_byte = e.b;
        end
        in_byte = 1;
        if (!dead_mode) begin
          rise_cd   = 1 + $urandom_range(0, 3);
          busy_len  = $urandom_range(bmin, bmax);
          gate_wait = 1;
        end
      end else if (in_byte && tx_busy) begin
        check("tx_data_hold", {24'b0, tx_data}, {24'b0, held_byte});
      end
      if (words_sent != prev_ws) begin
        check("words_sent", {16'b0, words_sent}, exp_words & 32'hFFFF);
        prev_ws = words_sent;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; address = a; dataIn = d;
    step();
    we = 1'b0;
    if (a == CTRL_ADDR) begin
      en_m = d[0]; nb_m = int'(d[2:1]); msb_m = d[3];
    end
  endtask

  // Expected order: little-endian byte list of the low nb_m+1 bytes, reversed when msb_first
  task automatic push(input logic [31:0] w);
    logic [7:0] bl[$];
    exp_t e;
    for (int i = 0; i <= nb_m; i++) begin
      if (msb_m) bl.push_front(w[i*8 +: 8]);
      else       bl.push_back(w[i*8 +: 8]);
    end
    for (int i = 0; i < bl.size(); i++) begin
      e.b = bl[i]; e.last = (i == bl.size() - 1);
      exp_q.push_back(e);
    end
    fifo_q.push_back(w);
    fifo_refresh();
  endtask

  task automatic drain(string name);
    int n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && idle && !tx_busy && rise_cd == 0) && n < 3000) begin
      step(); n++;
    end
    check({name, "_drain_timeout"}, {31'b0, n >= 3000}, 32'd0);
    check({name, "_words"}, {16'b0, words_sent}, exp_words & 32'hFFFF);
  endtask

  task automatic wait_ena(string name, input int e0);
    int n = 0;
    while (ena_cnt == e0 && n < 300) begin step(); n++; end
    check({name, "_ena_timeout"}, {31'b0, n >= 300}, 32'd0);
  endtask

  task automatic check_reset_outputs(string name);
    check({name, "_idle"}, {31'b0, idle}, 32'd1);
    check({name, "_tx_ena"}, {31'b0, tx_ena}, 32'd0);
    check({name, "_fifo_rd"}, {31'b0, fifo_rd}, 32'd0);
    check({name, "_tx_data"}, {24'b0, tx_data}, 32'd0);
    check({name, "_ack_err"}, {31'b0, ack_err}, 32'd0);
    check({name, "_words"}, {16'b0, words_sent}, 32'd0);
  endtask

  initial begin
    int e0, rd0, n;
    repeat (3) step();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    step();

    // default config: 4 bytes LSB first
    push(32'hA1B2C3D4);
    drain("dflt");
    check("dflt_rd_cnt", rd_cnt, 32'd1);
    check("dflt_idle", {31'b0, idle}, 32'd1);

    // MSB first, 2 bytes
    wr(CTRL_ADDR, 32'h0B);
    push(32'h0000_55AA);
    drain("msb2");
    check("msb2_rd_cnt", rd_cnt, 32'd2);

    // long busy pulses: gating and tx_data hold checked by the monitor
    wr(CTRL_ADDR, 32'h07);
    bmin = 20; bmax = 20;
    push($urandom);
    drain("gate");

    // ACK timeout with tx_busy never rising
    bmin = 2; bmax = 5;
    dead_mode = 1;
    e0 = ena_cnt;
    push($urandom);
    wait_ena("tmo", e0);
    repeat (ACK_TIMEOUT - 1) step();
    check("tmo_before", {31'b0, ack_err}, 32'd0);
    step();
    check("tmo_at", {31'b0, ack_err}, 32'd1);
    drain("tmo");
    check("tmo_bytes", ena_cnt - e0, 32'd4);
    dead_mode = 0;
    wr(32'h0000_1234, 32'h10);
    check("tmo_wrong_addr", {31'b0, ack_err}, 32'd1);
    wr(CTRL_ADDR, 32'h17);
    check("tmo_clear", {31'b0, ack_err}, 32'd0);

    // disable after the first byte of a two-word burst
    e0 = ena_cnt; rd0 = rd_cnt;
    push($urandom);
    push($urandom);
    wait_ena("dis", e0);
    wr(CTRL_ADDR, 32'h06);
    n = 0;
    while (!(exp_q.size() == 4 && idle) && n < 1000) begin step(); n++; end
    check("dis_first_done_timeout", {31'b0, n >= 1000}, 32'd0);
    repeat (10) step();
    check("dis_rd_cnt", rd_cnt - rd0, 32'd1);
    check("dis_fifo_left", fifo_q.size(), 32'd1);
    check("dis_idle", {31'b0, idle}, 32'd1);
    wr(CTRL_ADDR, 32'h07);
    drain("dis");
    check("dis_rd_cnt2", rd_cnt - rd0, 32'd2);

    // async reset while waiting for tx_busy to fall
    bmin = 20; bmax = 20;
    push($urandom);
    n = 0;
    while (!tx_busy && n < 300) begin step(); n++; end
    check("rstmid_busy_timeout", {31'b0, n >= 300}, 32'd0);
    step();
    #1;
    reset_n = 1'b0;
    exp_q.delete(); exp_words = 0; prev_ws = '0;
    en_m = 1; nb_m = 3; msb_m = 0;
    pop_pending = 0; rise_cd = 0; fall_cd = 0; tx_busy = 1'b0;
    gate_wait = 0; in_byte = 0;
    #1;
    check_reset_outputs("rstmid");
    step(); step();
    reset_n = 1'b1;
    e0 = ena_cnt; rd0 = rd_cnt;
    repeat (30) step();
    check("rstmid_no_ena", ena_cnt - e0, 32'd0);
    check("rstmid_no_rd", rd_cnt - rd0, 32'd0);
    bmin = 1; bmax = 4;
    push($urandom);
    drain("rstmid_after");

    // randomized configurations and busy timing
    for (int it = 0; it < 12; it++) begin
      logic [31:0] cfg;
      cfg = {28'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
      wr(CTRL_ADDR, cfg);
      bmin = 1; bmax = $urandom_range(1, 8);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) push($urandom);
      drain("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Sequences 32-bit words from the TX word FIFO into the byte-wide UART transmitter. Pops one word, splits it into 1-4 bytes in a configurable order, and issues one tx_ena per byte. Before issuing the next byte it waits for the transmitter's full busy rise/fall cycle. Sits between the CPU-side word FIFO (show-ahead read port) and the `uart` core. It is configured through a single memory-mapped control register on the CPU write bus.

Parameters:
- CTRL_ADDR, 32'h0000_7EF0, byte address of the control register.
- ACK_TIMEOUT, 16, max cycles to wait for tx_busy to rise after tx_ena.
- CNT_WIDTH, 16, width of the words_sent counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- we  in  1  CPU write strobe.
- address  in  32  CPU write address.
- dataIn  in  32  CPU write data.
- fifo_empty  in  1  word FIFO empty flag.
- fifo_data  in  32  head word of the FIFO; valid whenever fifo_empty=0.
- fifo_rd  out  1  one-cycle pop of the FIFO head.
- tx_ena  out  1  one-cycle send request to the uart core.
- tx_data  out  8  byte to transmit; held stable from the tx_ena cycle until WAIT_DONE exits.
- tx_busy  in  1  uart core busy.
- idle  out  1  1 when in IDLE with no word held.
- ack_err  out  1  sticky; set when an ACK timeout occurs.
- words_sent  out  CNT_WIDTH  count of words fully transmitted; wraps.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: fifo_rd=0, tx_ena=0, tx_data=0, idle=1, ack_err=0, words_sent=0.
  - Registers: state=IDLE, shift register=0, ctrl = enable=1, nbytes=3, msb_first=0.
- Control register:
  - Written when we=1 and address==CTRL_ADDR. The write takes effect the following cycle.
  - Bit 0 is enable.
  - Bits [2:1] are nbytes; bytes sent per word = nbytes+1.
  - Bit 3 is msb_first.
  - Bit 4 written as 1 clears ack_err. Bit 4 is self-clearing and is not stored.
  - Any other address is ignored.
- ack_err: writing bit4=1 in the same cycle as a timeout leaves ack_err=1 (set wins).
- Per-word config: enable, nbytes and msb_first are sampled in the LOAD cycle and held for that whole word. A mid-word register write affects only the next word.
- FSM:
  - IDLE: if enable=1 and fifo_empty=0 -> LOAD.
  - LOAD (1 cycle):
    - Assert fifo_rd=1.
    - Capture fifo_data into the shift register and set byte_cnt=0.
    - Latch the config -> SEND.
  - SEND:
    - If tx_busy=0: assert tx_ena=1 for exactly this cycle, driving the selected byte on tx_data -> WAIT_ACK.
    - Otherwise stay in SEND.
  - Byte selection:
    - msb_first=0: byte i = bits [8i+7:8i].
    - msb_first=1: the first byte is bits [8*nbytes+7:8*nbytes], then descending.
  - WAIT_ACK:
    - tx_busy=1 -> WAIT_DONE.
    - After ACK_TIMEOUT cycles without tx_busy=1: set ack_err=1 and go to NEXT; the byte counts as sent.
  - WAIT_DONE: tx_busy=0 -> NEXT.
  - NEXT (1 cycle):
    - If byte_cnt==nbytes: increment words_sent (wraps at 2^CNT_WIDTH), then -> IDLE if fifo_empty=1 or enable=0, else -> LOAD.
    - Otherwise increment byte_cnt -> SEND.
- Pop latency: fifo_rd is never asserted while fifo_empty=1.
- Back-to-back words: the minimum gap from the last byte's tx_busy fall to the next word's tx_ena is 3 cycles (NEXT, LOAD, SEND).
- Disable: enable=0 mid-word does not abort the word; all of its bytes are still sent.
- Reset mid-byte: returns to IDLE immediately. The partially sent word is lost and is not re-popped.
- idle = (state==IDLE).

Test Plan:
- Reset defaults:
  - Stimulus: push 32'hA1B2C3D4.
  - Required: tx_data sequence D4, C3, B2, A1; one fifo_rd pulse; words_sent=1; idle returns to 1.
- MSB-first, 2 bytes:
  - Stimulus: write ctrl=32'h0B (enable, nbytes=1, msb_first), then push 32'h0000_55AA.
  - Required: bytes 55, AA; words_sent=1.
- Handshake gating:
  - Stimulus: hold tx_busy=1 for 20 cycles after each tx_ena.
  - Required: no second tx_ena until tx_busy falls; tx_data stable throughout.
- ACK timeout:
  - Stimulus: tx_busy tied to 0.
  - Required: ack_err=1 exactly ACK_TIMEOUT cycles after the first tx_ena; all 4 bytes still issued.
  - Then: a ctrl write with bit4=1 clears ack_err.
- Disable mid-word:
  - Stimulus: push 2 words; write enable=0 after the first byte.
  - Required: the first word completes with 4 bytes; the second word stays in the FIFO (fifo_rd count=1).
  - Then: re-enable -> the second word is sent.
- Async reset mid-byte:
  - Stimulus: assert reset_n=0 while in WAIT_DONE.
  - Required: outputs go to reset values immediately; no further tx_ena until the FIFO is non-empty after release.
